// File: rtl/hydra_pkg.sv
// Shared sizes, FSM state type and the WRR credit-reload helper for the
// priority scheduler.
package hydra_pkg;
  localparam int NUM_PRIOR = 8;
  localparam int CNT_W     = 8;
  localparam int CREDIT_W  = 4;
  localparam int PRIOR_W   = 3;
  localparam int WEIGHT_W  = 3;

  typedef enum logic [1:0] {IDLE, GRANT, BUSY} state_e;

  // A weight w buys w+1 grants per visit, so a full 3-bit weight needs 4 bits.
  function automatic logic [CREDIT_W-1:0] credit_of(
    input logic [NUM_PRIOR*WEIGHT_W-1:0] weights,
    input logic [PRIOR_W-1:0]            idx
  );
    return CREDIT_W'(weights[int'(idx)*WEIGHT_W +: WEIGHT_W]) + CREDIT_W'(1);
  endfunction
endpackage

// File: rtl/prior_find.sv
// Find the first set request bit at or after a start index, wrapping 7 -> 0.
module prior_find
  import hydra_pkg::*;
(
  input  logic [NUM_PRIOR-1:0] req,
  input  logic [PRIOR_W-1:0]   start,
  output logic                 found,
  output logic [PRIOR_W-1:0]   idx
);
  // Scan from the far end so the closest hit to start overwrites the rest.
  always_comb begin
    found = 1'b0;
    idx   = start;
    for (int i = NUM_PRIOR - 1; i >= 0; i--) begin
      if (req[start + PRIOR_W'(i)]) begin
        found = 1'b1;
        idx   = start + PRIOR_W'(i);
      end
    end
  end
endmodule

// File: rtl/prior_scheduler.sv
// Eight per-priority packet counters feeding a strict / weighted round robin
// grant FSM with a one-outstanding-grant handshake to a read engine.
module prior_scheduler
  import hydra_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enq_vld,
  input  logic [PRIOR_W-1:0]            enq_prior,
  input  logic                          mode,
  input  logic [NUM_PRIOR*WEIGHT_W-1:0] wrr_weight,
  input  logic                          ready,
  input  logic                          done,
  output logic                          grant_vld,
  output logic [PRIOR_W-1:0]            grant_prior,
  output logic                          busy,
  output logic [NUM_PRIOR-1:0]          q_empty,
  output logic                          drop
);
  state_e               state_q, state_d;
  logic                 grant_vld_q, grant_vld_d;
  logic [PRIOR_W-1:0]   grant_prior_q, grant_prior_d;
  logic                 busy_q, busy_d;
  logic                 drop_q, drop_d;
  logic [PRIOR_W-1:0]   ptr_q, ptr_d;
  logic [CREDIT_W-1:0]  credit_q, credit_d;
  logic                 grant_wrr_q, grant_wrr_d;
  logic [NUM_PRIOR-1:0] nonempty;
  logic [NUM_PRIOR-1:0] full_hit;
  logic                 accept;
  logic [PRIOR_W-1:0]   find_start, find_idx;
  logic                 find_found;

  assign accept = grant_vld_q & ready;

  generate
    for (genvar gi = 0; gi < NUM_PRIOR; gi++) begin : g_cnt
      logic [CNT_W-1:0] cnt_q, cnt_d;
      logic             inc, dec;

      assign inc = enq_vld && (enq_prior == PRIOR_W'(gi));
      assign dec = accept && (grant_prior_q == PRIOR_W'(gi));
      assign nonempty[gi] = (cnt_q != '0);
      // A full counter still takes the enqueue when a grant frees a slot.
      assign full_hit[gi] = inc && !dec && (cnt_q == '1);

      always_comb begin
        cnt_d = cnt_q;
        if (inc && !dec && (cnt_q != '1)) begin
          cnt_d = cnt_q + 1'b1;
        end else if (dec && !inc) begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_d;
        end
      end
    end
  endgenerate

  assign find_start = mode ? (ptr_q + 1'b1) : '0;

  prior_find u_find (
    .req   (nonempty),
    .start (find_start),
    .found (find_found),
    .idx   (find_idx)
  );

  always_comb begin
    state_d       = state_q;
    grant_vld_d   = grant_vld_q;
    grant_prior_d = grant_prior_q;
    busy_d        = busy_q;
    ptr_d         = ptr_q;
    credit_d      = credit_q;
    grant_wrr_d   = grant_wrr_q;
    drop_d        = |full_hit;
    case (state_q)
      IDLE: begin
        if (find_found) begin
          state_d     = GRANT;
          grant_vld_d = 1'b1;
          grant_wrr_d = mode;
          if (mode && nonempty[ptr_q] && (credit_q != '0)) begin
            grant_prior_d = ptr_q;
          end else begin
            grant_prior_d = find_idx;
            if (mode) begin
              ptr_d    = find_idx;
              credit_d = credit_of(wrr_weight, find_idx);
            end
          end
        end
      end
      GRANT: begin
        if (ready) begin
          state_d     = BUSY;
          grant_vld_d = 1'b0;
          busy_d      = 1'b1;
          if (grant_wrr_q && (credit_q != '0)) begin
            credit_d = credit_q - 1'b1;
          end
        end
      end
      BUSY: begin
        if (done) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_vld_q   <= 1'b0;
      grant_prior_q <= '0;
      busy_q        <= 1'b0;
      drop_q        <= 1'b0;
      ptr_q         <= '0;
      credit_q      <= '0;
      grant_wrr_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      grant_vld_q   <= grant_vld_d;
      grant_prior_q <= grant_prior_d;
      busy_q        <= busy_d;
      drop_q        <= drop_d;
      ptr_q         <= ptr_d;
      credit_q      <= credit_d;
      grant_wrr_q   <= grant_wrr_d;
    end
  end

  assign grant_vld   = grant_vld_q;
  assign grant_prior = grant_prior_q;
  assign busy        = busy_q;
  assign drop        = drop_q;
  assign q_empty     = ~nonempty;
endmodule

// File: tb/tb_prior_scheduler.sv
// Directed bench for prior_scheduler: strict ordering, WRR sequencing,
// counter saturation, grant hold and reset abandonment.
module tb_prior_scheduler;
  logic        clk = 1'b0;
  logic        rst;
  logic        enq_vld;
  logic [2:0]  enq_prior;
  logic        mode;
  logic [23:0] wrr_weight;
  logic        ready;
  logic        done;
  logic        grant_vld;
  logic [2:0]  grant_prior;
  logic        busy;
  logic [7:0]  q_empty;
  logic        drop;

  int n_checks = 0;
  int n_fail   = 0;

  prior_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .enq_vld     (enq_vld),
    .enq_prior   (enq_prior),
    .mode        (mode),
    .wrr_weight  (wrr_weight),
    .ready       (ready),
    .done        (done),
    .grant_vld   (grant_vld),
    .grant_prior (grant_prior),
    .busy        (busy),
    .q_empty     (q_empty),
    .drop        (drop)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic enq(input logic [2:0] p);
    enq_vld   = 1'b1;
    enq_prior = p;
    step();
    enq_vld   = 1'b0;
  endtask

  task automatic pulse_reset();
    rst     = 1'b1;
    enq_vld = 1'b0;
    ready   = 1'b0;
    done    = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  // Wait (bounded) for a grant, accept it, then finish the read two cycles later.
  task automatic serve(output bit ok, output logic [2:0] pr);
    ok = 1'b0;
    pr = 3'd0;
    for (int i = 0; i < 50 && !ok; i++) begin
      if (grant_vld === 1'b1) begin
        ok = 1'b1;
        pr = grant_prior;
      end else begin
        step();
      end
    end
    if (ok) begin
      ready = 1'b1;
      step();
      ready = 1'b0;
      step();
      done = 1'b1;
      step();
      done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; enq_vld = 1'b0; enq_prior = 3'd0; mode = 1'b0;
    wrr_weight = 24'd0; ready = 1'b0; done = 1'b0;
    step();
    step();
    n_checks++;
    if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL reset_grant_vld: got %b expected 0", grant_vld); end
    n_checks++;
    if (grant_prior !== 3'd0) begin n_fail++; $display("FAIL reset_grant_prior: got %0d expected 0", grant_prior); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++;
    if (drop !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %b expected 0", drop); end
    n_checks++;
    if (q_empty !== 8'hFF) begin n_fail++; $display("FAIL reset_q_empty: got %h expected ff", q_empty); end
    rst = 1'b0;
    step(); step(); step();
    n_checks++;
    if (grant_vld !== 1'b0) begin n_fail++; $display("FAIL reset_no_spurious_grant: got %b expected 0", grant_vld); end
    $display("test_reset done");
  endtask

  task automatic test_strict();
    logic [2:0] exp_a [3] = '{3'd5, 3'd2, 3'd7};
    logic [2:0] exp_b [4] = '{3'd6, 3'd2, 3'd5, 3'd7};
    bit ok;
    logic [2:0] pr;
    pulse_reset();
    mode = 1'b0;
    // Only q5 is visible at the first selection; 2 then outranks 7.
    enq(3'd5); enq(3'd2); enq(3'd7);
    for (int i = 0; i < 3; i++) begin
      serve(ok, pr);
      n_checks++;
      if (!ok || pr !== exp_a[i]) begin
        n_fail++; $display("FAIL strict_idle_order[%0d]: got %0d (granted=%b) expected %0d", i, pr, ok, exp_a[i]);
      end
      $display("strict grant %0d -> q%0d", i, pr);
    end
    // With a pending grant blocking the FSM, all three are visible together.
    enq(3'd6); enq(3'd5); enq(3'd2); enq(3'd7);
    for (int i = 0; i < 4; i++) begin
      serve(ok, pr);
      n_checks++;
      if (!ok || pr !== exp_b[i]) begin
        n_fail++; $display("FAIL strict_blocked_order[%0d]: got %0d (granted=%b) expected %0d", i, pr, ok, exp_b[i]);
      end
      $display("strict blocked grant %0d -> q%0d", i, pr);
    end
    step();
    n_checks++;
    if (q_empty !== 8'hFF) begin n_fail++; $display("FAIL strict_q_empty_end: got %h expected ff", q_empty); end
  endtask

  task automatic test_wrr();
    logic [2:0] exp_o [8] = '{3'd0, 3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1};
    bit ok;
    logic [2:0] pr;
    pulse_reset();
    mode = 1'b1;
    wrr_weight = 24'h000001;
    for (int i = 0; i < 4; i++) enq(3'd0);
    for (int i = 0; i < 4; i++) enq(3'd1);
    for (int i = 0; i < 8; i++) begin
      serve(ok, pr);
      n_checks++;
      if (!ok || pr !== exp_o[i]) begin
        n_fail++; $display("FAIL wrr_order[%0d]: got %0d (granted=%b) expected %0d", i, pr, ok, exp_o[i]);
      end
      $display("wrr grant %0d -> q%0d", i, pr);
    end
    n_checks++;
    if (q_empty !== 8'hFF) begin n_fail++; $display("FAIL wrr_q_empty_end: got %h expected ff", q_empty); end
    mode = 1'b0;
    wrr_weight = 24'd0;
  endtask

  task automatic test_full();
    int drops = 0;
    int grants = 0;
    bit ok;
    logic [2:0] pr;
    pulse_reset();
    mode = 1'b0;
    for (int i = 0; i < 256; i++) begin
      enq_vld = 1'b1; enq_prior = 3'd3;
      step();
      if (drop === 1'b1) drops++;
    end
    enq_vld = 1'b0;
    step();
    if (drop === 1'b1) drops++;
    n_checks++;
    if (drops != 1) begin n_fail++; $display("FAIL full_drop_count: got %0d expected 1", drops); end
    n_checks++;
    if (grant_vld !== 1'b1 || grant_prior !== 3'd3) begin
      n_fail++; $display("FAIL full_pending_grant: got vld=%b prior=%0d expected vld=1 prior=3", grant_vld, grant_prior);
    end
    // Enqueue on the full queue in the same cycle its grant is accepted.
    enq_vld = 1'b1; enq_prior = 3'd3; ready = 1'b1;
    step();
    enq_vld = 1'b0; ready = 1'b0;
    n_checks++;
    if (drop !== 1'b0) begin n_fail++; $display("FAIL full_accept_no_drop: got %b expected 0", drop); end
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL full_accept_busy: got %b expected 1", busy); end
    done = 1'b1;
    step();
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      if (q_empty[3] === 1'b1) break;
      serve(ok, pr);
      if (!ok || pr !== 3'd3) begin
        n_checks++; n_fail++;
        $display("FAIL full_drain_grant: got %0d (granted=%b) expected 3", pr, ok);
        break;
      end
      grants++;
    end
    n_checks++;
    if (grants != 255) begin n_fail++; $display("FAIL full_remaining_count: got %0d expected 255", grants); end
    $display("full test: drops=%0d drained=%0d", drops, grants);
  endtask

  task automatic test_hold();
    bit ok;
    logic [2:0] pr;
    pulse_reset();
    mode = 1'b0;
    enq(3'd4);
    step();
    enq_vld = 1'b1; enq_prior = 3'd1; done = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      enq_vld = 1'b0;
      n_checks++;
      if (grant_vld !== 1'b1 || grant_prior !== 3'd4 || busy !== 1'b0) begin
        n_fail++; $display("FAIL hold_cycle[%0d]: got vld=%b prior=%0d busy=%b expected vld=1 prior=4 busy=0",
                           i, grant_vld, grant_prior, busy);
      end
    end
    done = 1'b0;
    serve(ok, pr);
    n_checks++;
    if (!ok || pr !== 3'd4) begin n_fail++; $display("FAIL hold_first: got %0d (granted=%b) expected 4", pr, ok); end
    serve(ok, pr);
    n_checks++;
    if (!ok || pr !== 3'd1) begin n_fail++; $display("FAIL hold_next: got %0d (granted=%b) expected 1", pr, ok); end
    $display("hold test: next grant q%0d", pr);
  endtask

  task automatic test_reset_busy();
    bit ok;
    bit seen;
    logic [2:0] pr;
    pulse_reset();
    mode = 1'b0;
    enq(3'd6); enq(3'd6); enq(3'd6);
    ready = 1'b1;
    step();
    ready = 1'b0;
    n_checks++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL rb_busy_before: got %b expected 1", busy); end
    rst = 1'b1;
    step();
    n_checks++;
    if (grant_vld !== 1'b0 || busy !== 1'b0 || grant_prior !== 3'd0 || drop !== 1'b0) begin
      n_fail++; $display("FAIL rb_outputs: got vld=%b busy=%b prior=%0d drop=%b expected all 0",
                         grant_vld, busy, grant_prior, drop);
    end
    n_checks++;
    if (q_empty !== 8'hFF) begin n_fail++; $display("FAIL rb_q_empty: got %h expected ff", q_empty); end
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (grant_vld === 1'b1) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin n_fail++; $display("FAIL rb_no_grant_after_reset: got grant expected none"); end
    enq(3'd2);
    serve(ok, pr);
    n_checks++;
    if (!ok || pr !== 3'd2) begin n_fail++; $display("FAIL rb_new_grant: got %0d (granted=%b) expected 2", pr, ok); end
    $display("reset-in-busy test: new grant q%0d", pr);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_strict();
    test_wrr();
    test_full();
    test_hold();
    test_reset_busy();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
